// File: rtl/swm_tx_arbiter.sv
// swm_tx_arbiter: two-requester Avalon-ST packet arbiter feeding a single TX lane.
// Round-robin packet-atomic grant, headless-beat dropping, per-requester packet
// counters and a sticky flag for a startofpacket seen in the middle of a packet.
module swm_tx_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic             clk_in_clk,
   input  logic             reset_in_rst,
   input  logic [31:0]      sink0_data,
   input  logic             sink0_valid,
   input  logic             sink0_startofpacket,
   input  logic             sink0_endofpacket,
   output logic             sink0_ready,
   input  logic [31:0]      sink1_data,
   input  logic             sink1_valid,
   input  logic             sink1_startofpacket,
   input  logic             sink1_endofpacket,
   output logic             sink1_ready,
   output logic [31:0]      src_data,
   output logic             src_valid,
   output logic             src_startofpacket,
   output logic             src_endofpacket,
   input  logic             src_ready,
   output logic             src_channel,
   output logic [CNT_W-1:0] pkt_count0,
   output logic [CNT_W-1:0] pkt_count1,
   output logic [CNT_W-1:0] drop_count,
   output logic             protocol_error
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic             first_q, first_d;
   logic [CNT_W-1:0] pkt_count0_q, pkt_count0_d;
   logic [CNT_W-1:0] pkt_count1_q, pkt_count1_d;
   logic [CNT_W-1:0] drop_count_q, drop_count_d;
   logic             perr_q, perr_d;

   logic             elig0, elig1;
   logic             gsel;
   logic [31:0]      sel_data;
   logic             sel_valid, sel_sop, sel_eop;

   assign elig0 = sink0_valid & sink0_startofpacket;
   assign elig1 = sink1_valid & sink1_startofpacket;

   // Next-state, counter updates and the combinational src/ready routing.
   always_comb begin
      state_d           = state_q;
      last_grant_d      = last_grant_q;
      first_d           = first_q;
      pkt_count0_d      = pkt_count0_q;
      pkt_count1_d      = pkt_count1_q;
      drop_count_d      = drop_count_q;
      perr_d            = perr_q;
      gsel              = 1'b0;
      sel_data          = '0;
      sel_valid         = 1'b0;
      sel_sop           = 1'b0;
      sel_eop           = 1'b0;
      src_data          = '0;
      src_valid         = 1'b0;
      src_startofpacket = 1'b0;
      src_endofpacket   = 1'b0;
      src_channel       = 1'b0;
      sink0_ready       = 1'b0;
      sink1_ready       = 1'b0;

      case (state_q)
         IDLE: begin
            // Beats without startofpacket cannot open a packet: swallow them.
            sink0_ready  = sink0_valid & ~sink0_startofpacket;
            sink1_ready  = sink1_valid & ~sink1_startofpacket;
            drop_count_d = drop_count_q + CNT_W'(sink0_ready) + CNT_W'(sink1_ready);
            // On a tie the requester that did not win last time goes first.
            if (elig0 && (!elig1 || last_grant_q)) begin
               state_d      = GRANT0;
               last_grant_d = 1'b0;
               first_d      = 1'b1;
            end else if (elig1) begin
               state_d      = GRANT1;
               last_grant_d = 1'b1;
               first_d      = 1'b1;
            end
         end
         GRANT0, GRANT1: begin
            gsel      = (state_q == GRANT1);
            sel_data  = gsel ? sink1_data          : sink0_data;
            sel_valid = gsel ? sink1_valid         : sink0_valid;
            sel_sop   = gsel ? sink1_startofpacket : sink0_startofpacket;
            sel_eop   = gsel ? sink1_endofpacket   : sink0_endofpacket;

            src_valid         = sel_valid;
            src_data          = sel_valid ? sel_data : '0;
            src_startofpacket = sel_sop;
            src_endofpacket   = sel_eop;
            src_channel       = gsel;
            sink0_ready       = ~gsel & src_ready;
            sink1_ready       =  gsel & src_ready;

            if (sel_valid && src_ready) begin
               first_d = 1'b0;
               // A second sop inside a packet is flagged but still forwarded.
               if (sel_sop && !first_q) begin
                  perr_d = 1'b1;
               end
               if (sel_eop) begin
                  state_d = IDLE;
                  if (gsel) begin
                     pkt_count1_d = pkt_count1_q + CNT_ONE;
                  end else begin
                     pkt_count0_d = pkt_count0_q + CNT_ONE;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Nothing is offered or accepted while reset is held.
      if (reset_in_rst) begin
         src_data          = '0;
         src_valid         = 1'b0;
         src_startofpacket = 1'b0;
         src_endofpacket   = 1'b0;
         src_channel       = 1'b0;
         sink0_ready       = 1'b0;
         sink1_ready       = 1'b0;
      end
   end

   // Arbiter state, grant history and statistics registers.
   always_ff @(posedge clk_in_clk) begin
      if (reset_in_rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         first_q      <= 1'b0;
         pkt_count0_q <= '0;
         pkt_count1_q <= '0;
         drop_count_q <= '0;
         perr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         first_q      <= first_d;
         pkt_count0_q <= pkt_count0_d;
         pkt_count1_q <= pkt_count1_d;
         drop_count_q <= drop_count_d;
         perr_q       <= perr_d;
      end
   end

   assign pkt_count0     = pkt_count0_q;
   assign pkt_count1     = pkt_count1_q;
   assign drop_count     = drop_count_q;
   assign protocol_error = perr_q;

endmodule

// File: tb/tb_swm_tx_arbiter.sv
// tb_swm_tx_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level model of the arbitration rules.
module tb_swm_tx_arbiter;

   localparam int CW    = 8;
   localparam int CMASK = (1 << CW) - 1;

   typedef struct {
      logic [31:0] d;
      logic        s;
      logic        e;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   d0, d1;
   logic          v0, s0, e0, v1, s1, e1;
   logic          src_ready;
   logic          sink0_ready, sink1_ready;
   logic [31:0]   src_data;
   logic          src_valid, src_startofpacket, src_endofpacket, src_channel;
   logic [CW-1:0] pkt_count0, pkt_count1, drop_count;
   logic          protocol_error;

   always #5 clk = ~clk;

   swm_tx_arbiter #(.CNT_W(CW)) dut (
      .clk_in_clk          (clk),
      .reset_in_rst        (rst),
      .sink0_data          (d0),
      .sink0_valid         (v0),
      .sink0_startofpacket (s0),
      .sink0_endofpacket   (e0),
      .sink0_ready         (sink0_ready),
      .sink1_data          (d1),
      .sink1_valid         (v1),
      .sink1_startofpacket (s1),
      .sink1_endofpacket   (e1),
      .sink1_ready         (sink1_ready),
      .src_data            (src_data),
      .src_valid           (src_valid),
      .src_startofpacket   (src_startofpacket),
      .src_endofpacket     (src_endofpacket),
      .src_ready           (src_ready),
      .src_channel         (src_channel),
      .pkt_count0          (pkt_count0),
      .pkt_count1          (pkt_count1),
      .drop_count          (drop_count),
      .protocol_error      (protocol_error)
   );

   int    checks = 0;
   int    errors = 0;
   beat_t q0[$];
   beat_t q1[$];
   int    gap_pct  = 0;
   bit    rnd_mode = 0;

   logic [31:0] cap_data;
   logic        cap_sv, cap_ch, cap_sop, cap_eop, cap_r0, cap_r1;

   // Reference model: who owns the lane (-1 = nobody), who won last, statistics.
   int m_owner = -1;
   int m_last  = 1;
   bit m_first = 0;
   int m_pkt0  = 0;
   int m_pkt1  = 0;
   int m_drop  = 0;
   bit m_perr  = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_check();
      logic [31:0] ed;
      bit ev, es, ee, ec, er0, er1;
      ed = '0; ev = 0; es = 0; ee = 0; ec = 0; er0 = 0; er1 = 0;
      if (!rst) begin
         if (m_owner < 0) begin
            er0 = v0 && !s0;
            er1 = v1 && !s1;
         end else if (m_owner == 0) begin
            ev = v0; ed = v0 ? d0 : 32'h0; es = s0; ee = e0; ec = 0; er0 = src_ready;
         end else begin
            ev = v1; ed = v1 ? d1 : 32'h0; es = s1; ee = e1; ec = 1; er1 = src_ready;
         end
      end
      check_eq("src_valid", cap_sv, ev);
      check_eq("src_data", cap_data, ed);
      check_eq("src_sop", cap_sop, es);
      check_eq("src_eop", cap_eop, ee);
      check_eq("src_channel", cap_ch, ec);
      check_eq("sink0_ready", cap_r0, er0);
      check_eq("sink1_ready", cap_r1, er1);
      check_eq("pkt_count0", pkt_count0, m_pkt0);
      check_eq("pkt_count1", pkt_count1, m_pkt1);
      check_eq("drop_count", drop_count, m_drop);
      check_eq("protocol_error", protocol_error, m_perr);
   endtask

   task automatic model_update();
      bit el0, el1, v, s, e;
      if (rst) begin
         m_owner = -1; m_last = 1; m_first = 0;
         m_pkt0 = 0; m_pkt1 = 0; m_drop = 0; m_perr = 0;
      end else if (m_owner < 0) begin
         if (v0 && !s0) m_drop = (m_drop + 1) & CMASK;
         if (v1 && !s1) m_drop = (m_drop + 1) & CMASK;
         el0 = v0 && s0;
         el1 = v1 && s1;
         if (el0 && el1) m_owner = 1 - m_last;
         else if (el0)   m_owner = 0;
         else if (el1)   m_owner = 1;
         if (m_owner >= 0) begin
            m_last  = m_owner;
            m_first = 1;
         end
      end else begin
         v = (m_owner == 0) ? v0 : v1;
         s = (m_owner == 0) ? s0 : s1;
         e = (m_owner == 0) ? e0 : e1;
         if (v && src_ready) begin
            if (s && !m_first) m_perr = 1;
            m_first = 0;
            if (e) begin
               if (m_owner == 0) m_pkt0 = (m_pkt0 + 1) & CMASK;
               else              m_pkt1 = (m_pkt1 + 1) & CMASK;
               m_owner = -1;
            end
         end
      end
   endtask

   task automatic push_pkt(input int ch, input int len, input int stray, input bit headless,
                           input logic [31:0] base);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.d = base + i;
         b.s = headless ? 1'b0 : ((i == 0) || (i == stray));
         b.e = (i == len - 1);
         if (ch == 0) q0.push_back(b);
         else         q1.push_back(b);
      end
   endtask

   task automatic push_rand(input int ch);
      int len, stray;
      len   = $urandom_range(1, 4);
      stray = (len > 1 && $urandom_range(7) == 0) ? $urandom_range(1, len - 1) : -1;
      push_pkt(ch, len, stray, ($urandom_range(7) == 0), $urandom);
   endtask

   task automatic drive();
      if (q0.size() > 0 && $urandom_range(99) >= gap_pct) begin
         v0 = 1; d0 = q0[0].d; s0 = q0[0].s; e0 = q0[0].e;
      end else begin
         v0 = 0; d0 = $urandom; s0 = 1'($urandom_range(1)); e0 = 1'($urandom_range(1));
      end
      if (q1.size() > 0 && $urandom_range(99) >= gap_pct) begin
         v1 = 1; d1 = q1[0].d; s1 = q1[0].s; e1 = q1[0].e;
      end else begin
         v1 = 0; d1 = $urandom; s1 = 1'($urandom_range(1)); e1 = 1'($urandom_range(1));
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cap_sv = src_valid; cap_data = src_data; cap_sop = src_startofpacket;
      cap_eop = src_endofpacket; cap_ch = src_channel;
      cap_r0 = sink0_ready; cap_r1 = sink1_ready;
      model_check();
      @(posedge clk);
      model_update();
      #1;
      if (v0 && cap_r0 && q0.size() > 0) void'(q0.pop_front());
      if (v1 && cap_r1 && q1.size() > 0) void'(q1.pop_front());
      if (rnd_mode) begin
         if (q0.size() == 0 && $urandom_range(3) == 0) push_rand(0);
         if (q1.size() == 0 && $urandom_range(3) == 0) push_rand(1);
      end
      drive();
   endtask

   task automatic rst_phase();
      rst = 1;
      q0.delete(); q1.delete();
      push_pkt(0, 1, -1, 1, 32'h0BAD_0000);
      push_pkt(1, 1, -1, 0, 32'h0BAD_1000);
      gap_pct = 0;
      drive();
      tick(); tick();
      check_eq("rst_sink0_ready", cap_r0, 0);
      check_eq("rst_sink1_ready", cap_r1, 0);
      check_eq("rst_src_valid", cap_sv, 0);
      check_eq("rst_pkt_count0", pkt_count0, 0);
      check_eq("rst_pkt_count1", pkt_count1, 0);
      check_eq("rst_drop_count", drop_count, 0);
      check_eq("rst_protocol_error", protocol_error, 0);
      q0.delete(); q1.delete();
      drive();
      tick();
      rst = 0;
   endtask

   initial begin
      rst = 1; src_ready = 0;
      v0 = 0; s0 = 0; e0 = 0; d0 = '0;
      v1 = 0; s1 = 0; e1 = 0; d1 = '0;
      rst_phase();

      // Tie after reset: requester 0 first, one idle cycle, then requester 1.
      src_ready = 1;
      push_pkt(0, 3, -1, 0, 32'hA000_0000);
      push_pkt(1, 3, -1, 0, 32'hB000_0000);
      drive();
      tick();
      check_eq("tie_arb_idle", cap_sv, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("tie_r0_valid", cap_sv, 1);
         check_eq("tie_r0_channel", cap_ch, 0);
         check_eq("tie_r0_data", cap_data, 32'hA000_0000 + i);
      end
      tick();
      check_eq("tie_gap_idle", cap_sv, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("tie_r1_channel", cap_ch, 1);
         check_eq("tie_r1_data", cap_data, 32'hB000_0000 + i);
      end
      tick();
      check_eq("tie_pkt_count0", pkt_count0, 1);
      check_eq("tie_pkt_count1", pkt_count1, 1);

      // Stall on beat 2 while requester 1 waits.
      push_pkt(0, 4, -1, 0, 32'hC000_0000);
      push_pkt(1, 2, -1, 0, 32'hD000_0000);
      drive();
      tick();
      tick();
      check_eq("stall_beat1", cap_data, 32'hC000_0000);
      src_ready = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("stall_hold_valid", cap_sv, 1);
         check_eq("stall_hold_channel", cap_ch, 0);
         check_eq("stall_hold_data", cap_data, 32'hC000_0001);
         check_eq("stall_sink1_ready", cap_r1, 0);
      end
      src_ready = 1;
      for (int i = 1; i < 4; i++) begin
         tick();
         check_eq("stall_order", cap_data, 32'hC000_0000 + i);
         check_eq("stall_channel", cap_ch, 0);
      end
      tick();
      check_eq("stall_idle", cap_sv, 0);
      tick();
      check_eq("stall_r1_first", cap_data, 32'hD000_0000);
      tick();
      tick();

      // Headless beats in IDLE are dropped.
      rst_phase();
      src_ready = 1;
      push_pkt(0, 2, -1, 1, 32'hE000_0000);
      drive();
      for (int i = 0; i < 2; i++) begin
         tick();
         check_eq("headless_ready", cap_r0, 1);
         check_eq("headless_src_valid", cap_sv, 0);
      end
      check_eq("headless_drop_count", drop_count, 2);

      // Single-beat packet on requester 1.
      push_pkt(1, 1, -1, 0, 32'h5157_0001);
      drive();
      tick();
      check_eq("single_arb", cap_sv, 0);
      tick();
      check_eq("single_valid", cap_sv, 1);
      check_eq("single_channel", cap_ch, 1);
      check_eq("single_eop", cap_eop, 1);
      check_eq("single_pkt_count1", pkt_count1, 1);
      tick();
      check_eq("single_back_idle", cap_sv, 0);

      // Stray sop on beat 2 is forwarded and flagged.
      push_pkt(0, 3, 1, 0, 32'h57A0_0000);
      drive();
      tick();
      tick();
      check_eq("stray_no_flag_yet", protocol_error, 0);
      tick();
      check_eq("stray_forwarded", cap_data, 32'h57A0_0001);
      check_eq("stray_sop_seen", cap_sop, 1);
      check_eq("stray_flag", protocol_error, 1);
      tick();
      tick();
      tick();
      check_eq("stray_flag_sticky", protocol_error, 1);

      // Counter wrap, then reset in the middle of a packet.
      rst_phase();
      src_ready = 1;
      for (int i = 0; i < CMASK; i++) push_pkt(0, 1, -1, 0, i);
      drive();
      for (int i = 0; i < 2000 && q0.size() > 0; i++) tick();
      check_eq("wrap_drained", q0.size(), 0);
      check_eq("wrap_at_max", pkt_count0, CMASK);
      push_pkt(0, 1, -1, 0, 32'hF00D_0000);
      drive();
      tick();
      tick();
      check_eq("wrap_to_zero", pkt_count0, 0);
      push_pkt(0, 3, -1, 0, 32'h6000_0000);
      drive();
      tick();
      tick();
      check_eq("rstmid_beat1", cap_data, 32'h6000_0000);
      rst = 1;
      tick();
      check_eq("rstmid_src_valid", cap_sv, 0);
      check_eq("rstmid_sink0_ready", cap_r0, 0);
      rst = 0;
      check_eq("rstmid_pkt_count0", pkt_count0, 0);
      check_eq("rstmid_drop_count", drop_count, 0);
      check_eq("rstmid_perr", protocol_error, 0);
      tick();
      check_eq("rstmid_idle_valid", cap_sv, 0);
      check_eq("rstmid_idle_data", cap_data, 0);
      check_eq("rstmid_idle_channel", cap_ch, 0);
      check_eq("rstmid_remainder_drop", cap_r0, 1);
      tick();
      check_eq("rstmid_drop_total", drop_count, 2);
      check_eq("rstmid_no_pkt", pkt_count0, 0);

      // Randomized traffic against the model.
      rnd_mode = 1;
      gap_pct  = 30;
      for (int i = 0; i < 4000; i++) begin
         src_ready = ($urandom_range(99) < 75);
         rst       = ($urandom_range(299) == 0);
         tick();
      end
      rst = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
